// File: rtl/nic8_pkg.sv
// nic8_pkg: shared widths, reset PC and fetch/execute state encoding for the nic8 front end.
package nic8_pkg;
    localparam int PC_W = 8;
    localparam int IR_W = 8;
    localparam logic [PC_W-1:0] PC_RESET_DEFAULT = 8'h00;
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WAIT  = 2'd2
    } seqState_e;
endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// pc_reg: 8-bit program counter, async clear to preset, sync load over increment (LS161 pair).
module pc_reg
    import nic8_pkg::*;
#(
    parameter logic [PC_W-1:0] PRESET = PC_RESET_DEFAULT
) (
    input  logic            clk,
    input  logic            clearBar,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);
    always_ff @(posedge clk or negedge clearBar) begin
        if (!clearBar) q <= PRESET;
        else if (load) q <= d;
        else if (inc) q <= q + 1'b1;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: nic8 PC, IR, fetch/exec FSM and retired-instruction counter.
// Optional SINGLE_STEP_EN adds the step port and a WAIT state after every EXEC.
module fetch_sequencer
    import nic8_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int              COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               resetBar,
    input  logic [IR_W-1:0]    romData,
    input  logic [PC_W-1:0]    dbus,
    input  logic               doJump,
    input  logic               assertBarRom,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic [PC_W-1:0]    pc,
    output logic [IR_W-1:0]    ir,
    output logic               fetching,
    output logic               retire,
    output logic [COUNT_W-1:0] instrCount
);
    seqState_e stateQ, stateD;
    assign fetching = (stateQ == FETCH);
    assign retire   = (stateQ == EXEC);
`ifdef SINGLE_STEP_EN
    logic stepQ, stepPending;
    logic stepRise;
    assign stepRise = step & ~stepQ;
    // A new rising edge in the cycle WAIT consumes the pending request re-arms it.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            stepQ       <= 1'b0;
            stepPending <= 1'b0;
        end else begin
            stepQ       <= step;
            stepPending <= stepRise | (stepPending & (stateQ != WAIT));
        end
    end
    always_comb begin
        stateD = FETCH;
        stateD = fetching ? EXEC : retire ? WAIT : (stateQ == WAIT && !stepPending) ? WAIT : FETCH;
    end
`else
    always_comb begin
        stateD = FETCH;
        stateD = fetching ? EXEC : FETCH;
    end
`endif
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) stateQ <= FETCH;
        else stateQ <= stateD;
    end
    pc_reg #(.PRESET(PC_RESET)) uPc (
        .clk     (clk),
        .clearBar(resetBar),
        .load    (retire & doJump),
        .inc     (fetching | (retire & ~assertBarRom)),
        .d       (dbus),
        .q       (pc)
    );
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) ir <= '0;
        else if (fetching) ir <= romData;
    end
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) instrCount <= '0;
        else if (retire) instrCount <= instrCount + COUNT_W'(1);
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven scoreboard bench for fetch_sequencer (plus SINGLE_STEP_EN sequences).
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        resetBar;
    logic [7:0]  romData, romData2, dbus, pc, ir, pc2, ir2;
    logic        doJump, assertBarRom, step;
    logic        fetching, retire, fetching2, retire2;
    logic [15:0] instrCount;
    logic [2:0]  instrCount2;
    logic [7:0]  rom [256];
    int          passed = 0;
    int          total = 0;

    typedef struct {
        logic       jmp;
        logic       abr;
        logic [7:0] dbusV;
        logic [7:0] expIr;
        logic [7:0] expPcF;
        logic [7:0] expPcE;
    } vec_t;
    typedef struct {
        logic [7:0]  ir;
        logic [7:0]  pcF;
        logic [7:0]  pcE;
        logic [15:0] cnt;
    } exp_t;
    vec_t vecs [9];
    exp_t sb [$];
    exp_t e;

    always #5 clk = ~clk;
    assign romData  = rom[pc];
    assign romData2 = rom[pc2];

    fetch_sequencer dut (
        .clk(clk), .resetBar(resetBar), .romData(romData), .dbus(dbus),
        .doJump(doJump), .assertBarRom(assertBarRom),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .pc(pc), .ir(ir), .fetching(fetching), .retire(retire), .instrCount(instrCount)
    );

    fetch_sequencer #(.COUNT_W(3)) dutSmall (
        .clk(clk), .resetBar(resetBar), .romData(romData2), .dbus(8'h00),
        .doJump(1'b0), .assertBarRom(1'b1),
`ifdef SINGLE_STEP_EN
        .step(1'b0),
`endif
        .pc(pc2), .ir(ir2), .fetching(fetching2), .retire(retire2), .instrCount(instrCount2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic doReset();
        resetBar = 1'b0;
        @(negedge clk);
        resetBar = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = ~i[7:0];
        rom[0] = 8'h12;
        rom[1] = 8'h34;
        vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h12, 8'h01, 8'h01};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h34, 8'h02, 8'h03};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'hFC, 8'h04, 8'h04};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'hFB, 8'h05, 8'h06};
        vecs[4] = '{1'b1, 1'b0, 8'h80, 8'hF9, 8'h07, 8'h80};
        vecs[5] = '{1'b1, 1'b1, 8'hFF, 8'h7F, 8'h81, 8'hFF};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[7] = '{1'b1, 1'b1, 8'hFE, 8'h12, 8'h01, 8'hFE};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 8'h01, 8'hFF, 8'h00};
        resetBar = 1'b0; doJump = 1'b0; assertBarRom = 1'b1; dbus = 8'h00; step = 1'b0;
        #2;
        check("rst_pc", pc, 8'h00);
        check("rst_ir", ir, 8'h00);
        check("rst_cnt", instrCount, 16'd0);
        check("rst_fetching", fetching, 1'b1);
        check("rst_retire", retire, 1'b0);
        @(negedge clk);
        resetBar = 1'b1;
        @(posedge clk); #1;
        check("pre_abort_retire", retire, 1'b1);
        #1 resetBar = 1'b0;
        #1;
        check("abort_pc", pc, 8'h00);
        check("abort_ir", ir, 8'h00);
        check("abort_cnt", instrCount, 16'd0);
        check("abort_fetching", fetching, 1'b1);
        check("abort_retire", retire, 1'b0);
        #2 resetBar = 1'b1;
        #3;
        check("post_abort_retire", retire, 1'b0);
        @(posedge clk); #1;
        check("first_fetch_ir", ir, 8'h12);
        check("first_fetch_pc", pc, 8'h01);
        check("first_fetch_fetching", fetching, 1'b0);
        @(posedge clk); #1;
        check("first_exec_pc", pc, 8'h01);
        check("first_exec_cnt", instrCount, 16'd1);
        check("first_exec_fetching", fetching, 1'b1);
        doReset();
`ifdef SINGLE_STEP_EN
        repeat (2) @(posedge clk);
        #1;
        check("ss_first_cnt", instrCount, 16'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("ss_wait_pc", pc, 8'h01);
            check("ss_wait_cnt", instrCount, 16'd1);
            check("ss_wait_flags", {fetching, retire}, 2'b00);
        end
        step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        check("ss_pending_wait", {fetching, retire}, 2'b00);
        @(posedge clk); #1;
        check("ss_step_fetch", fetching, 1'b1);
        @(posedge clk); #1;
        check("ss_step_exec", retire, 1'b1);
        check("ss_step_ir", ir, 8'h34);
        step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        check("ss_step_cnt", instrCount, 16'd2);
        check("ss_after_wait", {fetching, retire}, 2'b00);
        @(posedge clk); #1;
        check("ss_latched_fetch", fetching, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("ss_latched_cnt", instrCount, 16'd3);
        check("ss_latched_wait", {fetching, retire}, 2'b00);
`else
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{vecs[i].expIr, vecs[i].expPcF, vecs[i].expPcE, 16'(i + 1)});
            @(posedge clk); #1;
            check("fetch_ir", ir, sb[0].ir);
            check("fetch_pc", pc, sb[0].pcF);
            check("fetch_flags", {fetching, retire}, 2'b01);
            doJump = vecs[i].jmp; assertBarRom = vecs[i].abr; dbus = vecs[i].dbusV;
            @(posedge clk); #1;
            e = sb.pop_front();
            check("exec_pc", pc, e.pcE);
            check("exec_cnt", instrCount, e.cnt);
            check("exec_flags", {fetching, retire}, 2'b10);
            check("small_cnt_wrap", instrCount2, e.cnt[2:0]);
            doJump = 1'b0; assertBarRom = 1'b1; dbus = 8'h00;
        end
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
